// File: rtl/fadd_share_sched.sv
// Round-robin scheduler sharing one start/done float adder among NUM_REQ requesters.
// Optional `FADD_ZERO_BYPASS_EN: a ±0 operand skips the adder and answers directly.
module fadd_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_x,
  input  logic [32*NUM_REQ-1:0]  req_y,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_sum,
  output logic [1:0]             resp_overflow,
  output logic                   fa_start,
  output logic [31:0]            fa_x,
  output logic [31:0]            fa_y,
  input  logic                   fa_done,
  input  logic [31:0]            fa_sum,
  input  logic [1:0]             fa_overflow,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            op_count
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        sum_q, sum_d;
  logic [1:0]         ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic [15:0]        ops_q, ops_d;

  logic               found;
  logic [PTR_W-1:0]   gidx;
  logic [31:0]        gx, gy;
  logic               byp;
  logic [31:0]        byp_sum;

  // first valid requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        gidx  = PTR_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  assign gx = req_x[32*int'(gidx) +: 32];
  assign gy = req_y[32*int'(gidx) +: 32];

`ifdef FADD_ZERO_BYPASS_EN
  logic xz, yz;
  assign xz      = (gx[30:0] == 31'd0);
  assign yz      = (gy[30:0] == 31'd0);
  assign byp     = xz | yz;
  assign byp_sum = (xz && yz) ? {gx[31] & gy[31], 31'd0} :
                   (xz ? gy : gx);
`else
  assign byp     = 1'b0;
  assign byp_sum = gx;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= '0;
      tmo_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      ops_q   <= ops_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    tmo_d   = 1'b0;
    ops_d   = ops_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d = gidx;
          x_d   = gx;
          y_d   = gy;
          if (byp) begin
            sum_d   = byp_sum;
            ovf_d   = 2'b00;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done wins over a coincident timeout
        if (fa_done) begin
          sum_d   = fa_sum;
          ovf_d   = fa_overflow;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          sum_d   = 32'h7FC0_0000;
          ovf_d   = 2'b11;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rr_d    = (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        ops_d   = ops_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state_q == IDLE && rst && found) req_ready[gidx] = 1'b1;
    if (state_q == RESP) resp_valid[gnt_q] = 1'b1;
  end

  assign fa_start      = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign fa_x          = x_q;
  assign fa_y          = y_q;
  assign resp_sum      = sum_q;
  assign resp_overflow = ovf_q;
  assign timeout_err   = tmo_q;
  assign op_count      = ops_q;

endmodule

// File: tb/tb_fadd_share_sched.sv
// Directed bench for fadd_share_sched with a behavioural start/done adder stub.
// Honours FADD_ZERO_BYPASS_EN when selecting expected bypass latency.
module tb_fadd_share_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [32*N-1:0] req_x;
  logic [32*N-1:0] req_y;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [31:0]    resp_sum;
  logic [1:0]     resp_overflow;
  logic           fa_start;
  logic [31:0]    fa_x;
  logic [31:0]    fa_y;
  logic           fa_done;
  logic [31:0]    fa_sum;
  logic [1:0]     fa_overflow;
  logic           busy;
  logic           timeout_err;
  logic [15:0]    op_count;

  always #5 clk = ~clk;

  fadd_share_sched #(.NUM_REQ(N), .PTR_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_sum(resp_sum), .resp_overflow(resp_overflow),
    .fa_start(fa_start), .fa_x(fa_x), .fa_y(fa_y),
    .fa_done(fa_done), .fa_sum(fa_sum), .fa_overflow(fa_overflow),
    .busy(busy), .timeout_err(timeout_err), .op_count(op_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // hand-computed IEEE sums for the operand pairs used below
  function automatic logic [33:0] fadd_ref(input logic [31:0] x,
                                           input logic [31:0] y);
    case ({x, y})
      {32'h3F80_0000, 32'h4000_0000}: return {2'b00, 32'h4040_0000};
      {32'h4000_0000, 32'h4000_0000}: return {2'b00, 32'h4080_0000};
      {32'h3F80_0000, 32'h3F80_0000}: return {2'b00, 32'h4000_0000};
      {32'h4080_0000, 32'h3F80_0000}: return {2'b00, 32'h40A0_0000};
      {32'h7F7F_FFFF, 32'h7F7F_FFFF}: return {2'b01, 32'h7F80_0000};
      {32'h0000_0000, 32'hC0A0_0000}: return {2'b00, 32'hC0A0_0000};
      {32'h8000_0000, 32'h8000_0000}: return {2'b00, 32'h8000_0000};
      default:                        return 34'd0;
    endcase
  endfunction

  int          stub_d = 0;
  logic        done_stub = 1'b0;
  logic        done_stray = 1'b0;
  logic [31:0] stub_sum = '0;
  logic [1:0]  stub_ovf = '0;

  assign fa_done     = done_stub | done_stray;
  assign fa_sum      = stub_sum;
  assign fa_overflow = stub_ovf;

  // adder stub: done in WAIT cycle stub_d, never if stub_d < 0
  initial forever begin
    @(negedge clk);
    if (fa_start && stub_d >= 0) begin
      {stub_ovf, stub_sum} = fadd_ref(fa_x, fa_y);
      repeat (stub_d + 1) @(negedge clk);
      done_stub = 1'b1;
      @(negedge clk);
      done_stub = 1'b0;
    end
  end

  task automatic set_req(input int i, input logic [31:0] x,
                         input logic [31:0] y);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
  endtask

  task automatic launch(input logic [3:0] mask, input logic [3:0] want,
                        input string tag, input bit hold);
    @(negedge clk);
    req_valid = mask;
    #1;
    expect_eq(tag, {28'd0, req_ready}, {28'd0, want});
    @(posedge clk);
    #1;
    if (!hold) req_valid = '0;
  endtask

  task automatic step_resp(output int n, output bit saw_start);
    n = 0;
    saw_start = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      #1;
      if (fa_start) saw_start = 1'b1;
      if (resp_valid != '0) begin
        n = i;
        break;
      end
    end
    if (n == 0) expect_eq("resp_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit s;
    int hits;
    logic [31:0] tx [4];
    logic [31:0] ty [4];
    logic [31:0] ts [4];
    int ord1 [5];
    int ord2 [4];

    tx = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4080_0000};
    ty = '{32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
    ts = '{32'h4040_0000, 32'h4080_0000, 32'h4000_0000, 32'h40A0_0000};
    ord1 = '{0, 1, 2, 3, 0};
    ord2 = '{2, 3, 0, 1};

    rst = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    repeat (3) @(negedge clk);
    req_valid = 4'hF;
    #1;
    expect_eq("rst_busy", {31'd0, busy}, 32'd0);
    expect_eq("rst_ready", {28'd0, req_ready}, 32'd0);
    expect_eq("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    expect_eq("rst_fa_start", {31'd0, fa_start}, 32'd0);
    expect_eq("rst_op_count", {16'd0, op_count}, 32'd0);
    expect_eq("rst_timeout", {31'd0, timeout_err}, 32'd0);
    req_valid = '0;
    rst = 1'b1;

    set_req(0, 32'h3F80_0000, 32'h4000_0000);
    stub_d = 2;
    launch(4'b0001, 4'b0001, "t1_ready", 1'b0);
    expect_eq("t1_fa_start", {31'd0, fa_start}, 32'd1);
    expect_eq("t1_fa_x", fa_x, 32'h3F80_0000);
    expect_eq("t1_fa_y", fa_y, 32'h4000_0000);
    step_resp(n, s);
    expect_eq("t1_latency", n, 32'd5);
    expect_eq("t1_resp_valid", {28'd0, resp_valid}, 32'd1);
    expect_eq("t1_sum", resp_sum, 32'h4040_0000);
    expect_eq("t1_ovf", {30'd0, resp_overflow}, 32'd0);
    @(negedge clk);
    #1;
    expect_eq("t1_op_count", {16'd0, op_count}, 32'd1);
    expect_eq("t1_idle", {31'd0, busy}, 32'd0);
    expect_eq("t1_sum_hold", resp_sum, 32'h4040_0000);

    set_req(1, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
    stub_d = 1;
    launch(4'b0010, 4'b0010, "ovf_ready", 1'b0);
    step_resp(n, s);
    expect_eq("ovf_latency", n, 32'd4);
    expect_eq("ovf_sum", resp_sum, 32'h7F80_0000);
    expect_eq("ovf_status", {30'd0, resp_overflow}, 32'd1);

    do_reset();
    for (int i = 0; i < N; i++) set_req(i, tx[i], ty[i]);
    stub_d = 0;
    for (int k = 0; k < 5; k++) begin
      launch(4'hF, 4'(1 << ord1[k]), "rr0_ready", 1'b1);
      step_resp(n, s);
      expect_eq("rr0_latency", n, 32'd3);
      expect_eq("rr0_resp_valid", {28'd0, resp_valid},
                32'(1 << ord1[k]));
      expect_eq("rr0_sum", resp_sum, ts[ord1[k]]);
    end
    req_valid = '0;
    launch(4'b0010, 4'b0010, "rr_mid_ready", 1'b0);
    step_resp(n, s);
    expect_eq("rr_mid_sum", resp_sum, ts[1]);
    for (int k = 0; k < 4; k++) begin
      launch(4'hF, 4'(1 << ord2[k]), "rr2_ready", 1'b1);
      step_resp(n, s);
      expect_eq("rr2_resp_valid", {28'd0, resp_valid},
                32'(1 << ord2[k]));
      expect_eq("rr2_sum", resp_sum, ts[ord2[k]]);
    end
    req_valid = '0;
    @(negedge clk);
    #1;
    expect_eq("rr_op_count", {16'd0, op_count}, 32'd10);

    stub_d = -1;
    set_req(0, 32'h3F80_0000, 32'h4000_0000);
    launch(4'b0001, 4'b0001, "tmo_ready", 1'b0);
    step_resp(n, s);
    expect_eq("tmo_latency", n, 32'd66);
    expect_eq("tmo_err", {31'd0, timeout_err}, 32'd1);
    expect_eq("tmo_sum", resp_sum, 32'h7FC0_0000);
    expect_eq("tmo_ovf", {30'd0, resp_overflow}, 32'd3);
    @(negedge clk);
    #1;
    expect_eq("tmo_err_pulse", {31'd0, timeout_err}, 32'd0);
    stub_d = 1;
    launch(4'b0001, 4'b0001, "post_tmo_ready", 1'b0);
    step_resp(n, s);
    expect_eq("post_tmo_latency", n, 32'd4);
    expect_eq("post_tmo_sum", resp_sum, 32'h4040_0000);
    expect_eq("post_tmo_ovf", {30'd0, resp_overflow}, 32'd0);

    stub_d = 63;
    launch(4'b0010, 4'b0010, "tie_ready", 1'b0);
    step_resp(n, s);
    expect_eq("tie_latency", n, 32'd66);
    expect_eq("tie_err", {31'd0, timeout_err}, 32'd0);
    expect_eq("tie_sum", resp_sum, 32'h4080_0000);
    expect_eq("tie_ovf", {30'd0, resp_overflow}, 32'd0);

    stub_d = -1;
    launch(4'b0100, 4'b0100, "mrst_ready", 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_eq("mrst_busy", {31'd0, busy}, 32'd0);
    expect_eq("mrst_op_count", {16'd0, op_count}, 32'd0);
    done_stray = 1'b1;
    @(negedge clk);
    done_stray = 1'b0;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid != '0 || busy) hits++;
    end
    expect_eq("mrst_no_resp", hits, 32'd0);
    req_valid = 4'hF;
    #1;
    expect_eq("mrst_rr_ptr", {28'd0, req_ready}, 32'd1);
    req_valid = '0;

    stub_d = 0;
    set_req(3, 32'h0000_0000, 32'hC0A0_0000);
    launch(4'b1000, 4'b1000, "byp_ready", 1'b0);
    step_resp(n, s);
`ifdef FADD_ZERO_BYPASS_EN
    expect_eq("byp_latency", n, 32'd1);
    expect_eq("byp_no_start", {31'd0, s}, 32'd0);
`else
    expect_eq("byp_latency", n, 32'd3);
    expect_eq("byp_start", {31'd0, s}, 32'd1);
`endif
    expect_eq("byp_sum", resp_sum, 32'hC0A0_0000);
    expect_eq("byp_ovf", {30'd0, resp_overflow}, 32'd0);

    set_req(0, 32'h8000_0000, 32'h8000_0000);
    launch(4'b0001, 4'b0001, "negz_ready", 1'b0);
    step_resp(n, s);
`ifdef FADD_ZERO_BYPASS_EN
    expect_eq("negz_latency", n, 32'd1);
`else
    expect_eq("negz_latency", n, 32'd3);
`endif
    expect_eq("negz_sum", resp_sum, 32'h8000_0000);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fadd_share_sched.md
Name: fadd_share_sched

Overview:
- Round-robin scheduler that shares one multi-cycle float adder core (start/done interface, IEEE-754 single) among NUM_REQ requesters.
- Per request it accepts an operand pair, launches the adder, and waits for done with a timeout.
- It returns sum/overflow to the winning requester.
- Sits between the ALU issue logic and the float adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- PTR_W, 2, width of grant index/pointer (clog2 NUM_REQ)
- TIMEOUT, 64, max WAIT cycles before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_x  in  32*NUM_REQ  operand x, requester i at [32i+31:32i]
- req_y  in  32*NUM_REQ  operand y, same packing
- req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
- resp_sum  out  32  result, shared bus
- resp_overflow  out  2  00 ok, 01 overflow, 10 underflow, 11 invalid/timeout
- fa_start  out  1  one-cycle launch pulse to adder
- fa_x, fa_y  out  32 each  registered operands to adder, stable from ISSUE until return to IDLE
- fa_done  in  1  adder completion pulse
- fa_sum  in  32  adder result, valid with fa_done
- fa_overflow  in  2  adder status, valid with fa_done
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  one-cycle pulse on abort
- op_count  out  16  completed operations, wraps at 16'hFFFF->0

Behaviour:
- Reset (rst==0 sampled at posedge):
  - state=IDLE, rr_ptr=0, all outputs 0, op_count=0.
  - Applies mid-operation too: the in-flight op is dropped, no resp_valid is issued, and a later fa_done is ignored because the scheduler is in IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = onehot(g), combinational, only in IDLE and only if some req_valid.
  - On that edge, capture x/y of g into fa_x/fa_y, store g, go to ISSUE.
  - No valid: stay in IDLE, req_ready=0.
- ISSUE: fa_start=1 for exactly this cycle; clear wait counter; go to WAIT. fa_done in this cycle is ignored.
- WAIT: counter increments each cycle.
  - fa_done=1: latch fa_sum/fa_overflow into resp_sum/resp_overflow, go to RESP.
  - Else if counter==TIMEOUT-1: resp_sum=32'h7FC00000, resp_overflow=2'b11, timeout_err=1 for one cycle, go to RESP.
  - fa_done has priority over timeout in the same cycle.
- RESP:
  - resp_valid[g]=1 for one cycle.
  - rr_ptr = g+1 mod NUM_REQ.
  - op_count+1 (timeouts included).
  - Go to IDLE.
- resp_sum/resp_overflow hold their value until the next latch.
- Latency: accept edge -> resp_valid = 3 + D cycles, where D = WAIT cycles until fa_done (D>=0; D=0 means done in the first WAIT cycle). Back-to-back throughput is one op per 4+D cycles.
- Fairness: a continuously valid requester is served within NUM_REQ grants.
- Requesters must hold req_valid/data stable until ready. Deasserting early is legal; that requester is simply not granted.
- Simultaneous valid on all lines with rr_ptr=0: grant order is 0,1,2,3,0...
- A new request is never accepted in ISSUE, WAIT or RESP.

Optional Feature:
- Macro: FADD_ZERO_BYPASS_EN.
- Defined: in IDLE, if the granted x or y is ±0 (bits[30:0]==0), skip ISSUE/WAIT.
  - resp_sum = the other operand. If both are zero: sign = x[31]&y[31], rest 0.
  - resp_overflow=00, go directly to RESP. Latency is 1 cycle and fa_start is never pulsed.
- Not defined: zero operands go through the adder like any other op.

Test Plan:
- Single op: req_valid=0001, x=3F800000, y=40000000; adder model returns 40400000/00 with D=2 -> req_ready[0] pulse, fa_start one cycle later, resp_valid=0001 at accept+5, resp_sum=40400000, op_count=1.
- All four requesters valid continuously, rr_ptr=0 -> grants 0,1,2,3,0; each resp_valid matches its own operands. Repeat from rr_ptr=2 after reset-less run -> order 2,3,0,1.
- Adder never asserts done, TIMEOUT=64 -> timeout_err pulse and resp_sum=7FC00000, resp_overflow=11 exactly 64 WAIT cycles after fa_start; next request is then served normally.
- rst=0 for one cycle during WAIT, then stray fa_done -> no resp_valid, busy=0, op_count=0, rr_ptr=0.
- Bypass (macro on): x=00000000, y=C0A00000 -> resp_sum=C0A00000 one cycle after accept, fa_start stays 0. Macro off: fa_start pulses.
- fa_done and timeout in same cycle -> adder result returned, timeout_err=0.
